// File: rtl/a51_lfsr_reg.sv
// A5/1-style clock-controlled LFSR register with its own serial load sequencer.
// One instance per cipher register; stepping in RUN comes from shared majority logic.
module a51_lfsr_reg #(
    parameter int             LEN       = 22,
    parameter logic [LEN-1:0] TAP_MASK  = 22'h300000,
    parameter int             CLK_BIT   = 10,
    parameter int             LOAD_BITS = 86,
    parameter int             CNT_W     = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           shift_bit,
    input  logic           step,
    input  logic           par_load,
    input  logic [LEN-1:0] par_data,
    output logic           busy,
    output logic           load_done,
    output logic           run,
    output logic           out_bit,
    output logic           clk_bit
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [LEN-1:0]   reg_q, reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_done_q, load_done_d;

    // True left shift: bit LEN-1 drops out, feedback XOR serial input enters at bit 0.
    function automatic logic [LEN-1:0] lfsr_shift(input logic [LEN-1:0] r, input logic in_bit);
        lfsr_shift = {r[LEN-2:0], (^(r & TAP_MASK)) ^ in_bit};
    endfunction

    always_comb begin
        state_d     = state_q;
        reg_d       = reg_q;
        cnt_d       = cnt_q;
        load_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    reg_d   = '0;
                    cnt_d   = '0;
                    state_d = LOAD;
                end else if (par_load) begin
                    reg_d   = par_data;
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (start) begin
                    reg_d = '0;
                    cnt_d = '0;
                end else begin
                    reg_d = lfsr_shift(reg_q, shift_bit);
                    if (cnt_q == CNT_W'(LOAD_BITS - 1)) begin
                        cnt_d       = '0;
                        state_d     = RUN;
                        load_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (start) begin
                    reg_d   = '0;
                    cnt_d   = '0;
                    state_d = LOAD;
                end else if (par_load) begin
                    reg_d = par_data;
                end else if (step) begin
                    reg_d = lfsr_shift(reg_q, 1'b0);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            reg_q       <= '0;
            cnt_q       <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            cnt_q       <= cnt_d;
            load_done_q <= load_done_d;
        end
    end

    assign busy      = (state_q == LOAD);
    assign run       = (state_q == RUN);
    assign load_done = load_done_q;
    assign out_bit   = reg_q[LEN-1];
    assign clk_bit   = reg_q[CLK_BIT];

endmodule
